alarm_sequencer: RTL and testbench

Sequencing controller for the security chip's alarm path: it arms and disarms the system, runs exit/entry/siren timers, and qualifies sensor events. It also checks a 4-digit keypad code with a failed-attempt lockout. It sits between the keypad/sensor pins and the siren/status outputs.

---
 rtl/sec_pkg.sv | 21 ++
 rtl/sec_code_checker.sv | 104 ++++++++++
 rtl/alarm_sequencer.sv | 149 ++++++++++++++
 tb/tb_alarm_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sec_pkg.sv
// Shared types and constants for the alarm sequencer and its keypad code checker.
package sec_pkg;

    // Main sequencer states; encodings are visible on the state output.
    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_t;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned CODE_LEN = 4;
    localparam int unsigned CODE_W   = CODE_LEN * DIGIT_W;
    // Only the first CODE_LEN-1 digits are stored; the last one is compared as it arrives.
    localparam int unsigned BUF_W    = (CODE_LEN - 1) * DIGIT_W;

    localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hF;

endpackage

// File: rtl/sec_code_checker.sv
// Keypad code checker: collects digits, compares a full code against CODE,
// counts consecutive failures and locks the keypad out after MAX_TRIES.
module sec_code_checker
    import sec_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE      = 16'h1234,
    parameter int unsigned       MAX_TRIES = 3,
    parameter int unsigned       LOCK_LEN  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    output logic               code_hit,
    output logic               code_ok,
    output logic               code_bad,
    output logic               lockout
);

    localparam int unsigned CNT_W = $clog2(CODE_LEN);
    localparam int unsigned FW    = $clog2(MAX_TRIES + 1);
    localparam int unsigned LW    = $clog2(LOCK_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CODE_LEN - 1);
    localparam logic [FW-1:0]    FAIL_LAST = FW'(MAX_TRIES - 1);

    logic [BUF_W-1:0] digits_q;
    logic [CNT_W-1:0] count_q;
    logic [FW-1:0]    fails_q;
    logic [LW-1:0]    lock_cnt_q;
    logic             lock_q;
    logic             ok_q;
    logic             bad_q;

    logic accept;
    logic is_clear;
    logic complete;
    logic match;
    logic miss;

    // Decode the current key; code_hit is combinational so the sequencer can
    // change state on the same edge that registers code_ok.
    always_comb begin
        accept   = key_valid && !lock_q;
        is_clear = (key_digit == KEY_CLEAR);
        complete = accept && !is_clear && (count_q == LAST_IDX);
        match    = ({digits_q, key_digit} == CODE);
        code_hit = complete && match;
        miss     = complete && !match;
    end

    // Digit buffer, fail counter, result pulses and lockout timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q   <= '0;
            count_q    <= '0;
            fails_q    <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            ok_q       <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            ok_q  <= code_hit;
            bad_q <= miss;

            if (accept) begin
                if (is_clear || complete) begin
                    digits_q <= '0;
                    count_q  <= '0;
                end else begin
                    digits_q <= {digits_q[BUF_W-DIGIT_W-1:0], key_digit};
                    count_q  <= count_q + CNT_W'(1);
                end
            end

            if (code_hit) begin
                fails_q <= '0;
            end else if (miss) begin
                if (fails_q == FAIL_LAST) begin
                    fails_q    <= '0;
                    lock_q     <= 1'b1;
                    lock_cnt_q <= LW'(LOCK_LEN);
                end else begin
                    fails_q <= fails_q + FW'(1);
                end
            end

            // Keys are never accepted while locked, so this cannot collide with a new lockout.
            if (lock_q) begin
                if (lock_cnt_q == LW'(1)) begin
                    lock_q     <= 1'b0;
                    lock_cnt_q <= '0;
                end else begin
                    lock_cnt_q <= lock_cnt_q - LW'(1);
                end
            end
        end
    end

    assign code_ok  = ok_q;
    assign code_bad = bad_q;
    assign lockout  = lock_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm path controller: arm/disarm FSM with exit, entry and siren timers,
// sensor qualification and a keypad code checker with lockout.
module alarm_sequencer
    import sec_pkg::*;
#(
    parameter int unsigned       EXIT_DLY  = 8,
    parameter int unsigned       ENTRY_DLY = 6,
    parameter int unsigned       SIREN_LEN = 10,
    parameter logic [CODE_W-1:0] CODE      = 16'h1234,
    parameter int unsigned       MAX_TRIES = 3,
    parameter int unsigned       LOCK_LEN  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm_req,
    input  logic [2:0]         sensor,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    output logic [2:0]         state,
    output logic               siren,
    output logic               armed,
    output logic               arm_fault,
    output logic               code_ok,
    output logic               code_bad,
    output logic               lockout
);

    localparam int unsigned TMAX01 = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int unsigned TMAX   = (TMAX01 > SIREN_LEN) ? TMAX01 : SIREN_LEN;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    state_t        state_q, state_nx;
    logic [TW-1:0] timer_q, timer_nx;
    logic          fault_nx;
    logic          siren_q, siren_nx;
    logic          armed_q, armed_nx;
    logic          fault_q;
    logic          code_hit;
    logic          door;
    logic          instant;
    logic          expired;

    sec_code_checker #(
        .CODE      (CODE),
        .MAX_TRIES (MAX_TRIES),
        .LOCK_LEN  (LOCK_LEN)
    ) u_code (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .code_hit  (code_hit),
        .code_ok   (code_ok),
        .code_bad  (code_bad),
        .lockout   (lockout)
    );

    // State, timer and registered outputs; reset drops the siren asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISARMED;
            timer_q <= '0;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            timer_q <= timer_nx;
            siren_q <= siren_nx;
            armed_q <= armed_nx;
            fault_q <= fault_nx;
        end
    end

    // Next state and timer; a correct code overrides expiry and sensors.
    always_comb begin
        door     = sensor[0];
        instant  = |sensor[2:1];
        expired  = (timer_q == TW'(1));
        state_nx = state_q;
        timer_nx = timer_q;
        fault_nx = 1'b0;
        unique case (state_q)
            DISARMED: begin
                if (arm_req) begin
                    if (sensor == 3'b000) begin
                        state_nx = EXIT_DELAY;
                        timer_nx = TW'(EXIT_DLY);
                    end else begin
                        fault_nx = 1'b1;
                    end
                end
            end
            EXIT_DELAY: begin
                if (expired) begin
                    state_nx = ARMED;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer_q - TW'(1);
                end
            end
            ARMED: begin
                if (instant) begin
                    state_nx = ALARM;
                    timer_nx = TW'(SIREN_LEN);
                end else if (door) begin
                    state_nx = ENTRY_DELAY;
                    timer_nx = TW'(ENTRY_DLY);
                end
            end
            ENTRY_DELAY: begin
                if (instant || expired) begin
                    state_nx = ALARM;
                    timer_nx = TW'(SIREN_LEN);
                end else begin
                    timer_nx = timer_q - TW'(1);
                end
            end
            ALARM: begin
                if (expired) begin
                    state_nx = ARMED;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer_q - TW'(1);
                end
            end
            default: begin
                state_nx = DISARMED;
                timer_nx = '0;
            end
        endcase
        if (code_hit && (state_q != DISARMED)) begin
            state_nx = DISARMED;
            timer_nx = '0;
        end
    end

    // Output decode from the next state so siren/armed register alongside it.
    always_comb begin
        siren_nx = (state_nx == ALARM);
        armed_nx = (state_nx == ARMED) || (state_nx == ENTRY_DELAY) || (state_nx == ALARM);
    end

    assign state     = state_q;
    assign siren     = siren_q;
    assign armed     = armed_q;
    assign arm_fault = fault_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer with default parameters.
module tb_alarm_sequencer;

    logic       clk;
    logic       rst_n;
    logic       arm_req;
    logic [2:0] sensor;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [2:0] state;
    logic       siren, armed, arm_fault, code_ok, code_bad, lockout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       arm;
        logic [2:0] sens;
        logic       kv;
        logic [3:0] kd;
        logic [8:0] exp; // {state, siren, armed, arm_fault, code_ok, code_bad, lockout}
    } vec_t;

    vec_t tbl[$];

    alarm_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm_req   (arm_req),
        .sensor    (sensor),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .state     (state),
        .siren     (siren),
        .armed     (armed),
        .arm_fault (arm_fault),
        .code_ok   (code_ok),
        .code_bad  (code_bad),
        .lockout   (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic arm, input logic [2:0] sens, input logic kv, input logic [3:0] kd,
                       input logic [2:0] st, input logic sir, input logic arm_o, input logic flt,
                       input logic ok, input logic bad, input logic lk);
        vec_t v;
        v.arm  = arm;
        v.sens = sens;
        v.kv   = kv;
        v.kd   = kd;
        v.exp  = {st, sir, arm_o, flt, ok, bad, lk};
        tbl.push_back(v);
    endtask

    // Four keys; only the last one produces a pulse.
    task automatic add_code(input logic [15:0] code, input logic [2:0] st, input logic arm_o,
                            input logic [2:0] st_last, input logic arm_last, input logic ok, input logic bad);
        logic [15:0] c;
        c = code;
        add(0, 3'b000, 1, c[15:12], st, 0, arm_o, 0, 0, 0, 0);
        add(0, 3'b000, 1, c[11:8],  st, 0, arm_o, 0, 0, 0, 0);
        add(0, 3'b000, 1, c[7:4],   st, 0, arm_o, 0, 0, 0, 0);
        add(0, 3'b000, 1, c[3:0],   st_last, 0, arm_last, 0, ok, bad, 0);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'h0;
    endtask

    task automatic arm_and_wait(input string tag);
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
        chk({tag, " exit_entered"}, 32'(state), 32'd1);
        repeat (7) step();
        chk({tag, " exit_still"}, 32'(state), 32'd1);
        step();
        chk({tag, " armed_state"}, 32'(state), 32'd2);
        chk({tag, " armed_flag"}, 32'(armed), 32'd1);
    endtask

    initial begin
        logic [8:0] got;
        rst_n     = 1'b0;
        arm_req   = 1'b0;
        sensor    = 3'b000;
        key_valid = 1'b0;
        key_digit = 4'h0;

        // Vector table: each row is applied for one clock, outputs compared after it.
        add(1, 3'b010, 0, 0, 3'd0, 0, 0, 1, 0, 0, 0);        // arm with window open -> fault
        add(0, 3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        add(1, 3'b000, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);        // arm -> EXIT_DELAY
        for (int i = 0; i < 7; i++)                          // sensors and arm_req ignored
            add((i == 3) ? 1'b1 : 1'b0, (i == 2) ? 3'b111 : 3'b000, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 3'd2, 0, 1, 0, 0, 0, 0);        // 8th cycle ends -> ARMED
        add(0, 3'b001, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0);        // door -> ENTRY_DELAY
        add_code(16'h1234, 3'd3, 1, 3'd0, 0, 1, 0);          // disarm in entry delay
        add(0, 3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        add_code(16'h1234, 3'd0, 0, 3'd0, 0, 1, 0);          // code while disarmed: pulse only
        add(0, 3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 1, 4'h1, 3'd0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 1, 4'h2, 3'd0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 1, 4'hF, 3'd0, 0, 0, 0, 0, 0, 0);     // clear, no pulse
        add_code(16'h1234, 3'd0, 0, 3'd0, 0, 1, 0);
        add_code(16'h1235, 3'd0, 0, 3'd0, 0, 0, 1);          // wrong last digit
        add_code(16'h1234, 3'd0, 0, 3'd0, 0, 1, 0);          // clears fail counter
        add(0, 3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);

        step();
        step();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outputs", 32'({siren, armed, arm_fault, code_ok, code_bad, lockout}), 32'd0);
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            arm_req   = tbl[i].arm;
            sensor    = tbl[i].sens;
            key_valid = tbl[i].kv;
            key_digit = tbl[i].kd;
            step();
            got = {state, siren, armed, arm_fault, code_ok, code_bad, lockout};
            chk($sformatf("vec[%0d]", i), 32'(got), 32'(tbl[i].exp));
        end
        arm_req = 1'b0; sensor = 3'b000; key_valid = 1'b0; key_digit = 4'h0;

        // Instant zones from ARMED: siren for exactly SIREN_LEN cycles, then auto re-arm.
        arm_and_wait("alarm");
        sensor = 3'b110;
        step();
        sensor = 3'b000;
        chk("alarm_state", 32'(state), 32'd4);
        chk("alarm_siren_on", 32'(siren), 32'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("alarm_hold[%0d]", i), 32'({state, siren}), 32'({3'd4, 1'b1}));
        end
        step();
        chk("rearm_state", 32'(state), 32'd2);
        chk("rearm_siren_off", 32'(siren), 32'd0);
        chk("rearm_armed", 32'(armed), 32'd1);
        sensor = 3'b011;                                     // door plus window together
        step();
        sensor = 3'b000;
        chk("door_plus_instant", 32'(state), 32'd4);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        chk("disarm_in_alarm", 32'({state, siren, armed, code_ok}), 32'({3'd0, 1'b0, 1'b0, 1'b1}));

        // Correct 4th digit lands on the entry-delay expiry edge: code wins.
        arm_and_wait("race");
        sensor = 3'b001;
        step();
        sensor = 3'b000;
        chk("race_entry", 32'(state), 32'd3);
        step();
        step();
        key(4'h1); key(4'h2); key(4'h3);
        chk("race_pre", 32'(state), 32'd3);
        key(4'h4);
        chk("race_disarmed", 32'({state, siren, armed, code_ok}), 32'({3'd0, 1'b0, 1'b0, 1'b1}));

        // Entry delay expiring without a code raises the alarm after exactly ENTRY_DLY cycles.
        arm_and_wait("expire");
        sensor = 3'b001;
        step();
        sensor = 3'b000;
        repeat (5) step();
        chk("entry_last_cycle", 32'(state), 32'd3);
        step();
        chk("entry_expired", 32'({state, siren}), 32'({3'd4, 1'b1}));

        // Asynchronous reset in the middle of a cycle drops the siren at once.
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_siren", 32'(siren), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Three bad codes in a row lock the keypad for LOCK_LEN cycles.
        for (int t = 0; t < 3; t++) begin
            key(4'h9); key(4'h9); key(4'h9); key(4'h9);
            chk($sformatf("bad_pulse[%0d]", t), 32'(code_bad), 32'd1);
            chk($sformatf("lock_after[%0d]", t), 32'(lockout), (t == 2) ? 32'd1 : 32'd0);
        end
        for (int s = 1; s <= 24; s++) begin
            key_valid = 1'b0;
            key_digit = 4'h0;
            if (s <= 4) begin
                key_valid = 1'b1;
                key_digit = 4'(s);
            end else if (s == 20) begin
                key_valid = 1'b1;                            // arrives as lockout drops: ignored
                key_digit = 4'h1;
            end else if (s >= 21) begin
                key_valid = 1'b1;
                key_digit = 4'(s - 20);
            end
            step();
            chk($sformatf("lock_s%0d", s), 32'({lockout, code_ok, code_bad}),
                32'({(s < 20) ? 1'b1 : 1'b0, (s == 24) ? 1'b1 : 1'b0, 1'b0}));
        end
        key_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
